// File: rtl/drt_device_finder.sv
// drt_device_finder: Wishbone master that walks the Device ROM Table looking for a device ID under a mask.
// Latency: one bus read per DRT word visited, then 2 clocks to finish; o_done pulses as o_busy falls.
// Backpressure: every read waits for ack, then for ack to drop, before the next read starts.
// Optional: DRT_FINDER_TIMEOUT_EN aborts a read that gets no ack (or keeps ack high) for TIMEOUT_CYCLES.
module drt_device_finder #(
  parameter logic [31:0] DRT_BASE_ADR    = 32'h00000000,
  parameter int unsigned DRT_HEADER_SIZE = 8,
  parameter int unsigned DRT_DEV_SIZE    = 8,
  parameter int unsigned MAX_DEVICES     = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_dev_id,
  input  logic [31:0] i_dev_mask,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_found,
  output logic        o_timeout,
  output logic [7:0]  o_dev_index,
  output logic [31:0] o_mem_offset,
  output logic [31:0] o_mem_size,
  output logic        o_wbm_cyc,
  output logic        o_wbm_stb,
  output logic        o_wbm_we,
  output logic [3:0]  o_wbm_sel,
  output logic [31:0] o_wbm_adr,
  output logic [31:0] o_wbm_dat,
  input  logic [31:0] i_wbm_dat,
  input  logic        i_wbm_ack,
  input  logic        i_wbm_int
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT_ACK, S_WAIT_ACK_LOW, S_EVAL, S_DONE} state_t;
  typedef enum logic [1:0] {PH_COUNT, PH_ID, PH_OFF, PH_SIZE} phase_t;

  state_t      r_state, w_state_nxt;
  phase_t      r_phase;
  logic [31:0] r_data, r_id, r_mask, r_adr, r_mem_offset, r_mem_size;
  logic [7:0]  r_idx, r_count, r_dev_index;
  logic        r_cyc, r_stb, r_busy, r_done, r_found, r_timeout;
  logic [7:0]  w_count_clamped, w_idx_inc;
  logic        w_id_match, w_last, w_timeout_hit;
  logic        w_unused_int;

  // Word address of a field inside device entry idx (wraps mod 2^32).
  function automatic logic [31:0] entry_adr(input logic [7:0] idx, input logic [1:0] field);
    entry_adr = DRT_BASE_ADR + 32'(DRT_HEADER_SIZE) + (32'(idx) * 32'(DRT_DEV_SIZE)) + 32'(field);
  endfunction

  assign w_count_clamped = (r_data > 32'(MAX_DEVICES)) ? 8'(MAX_DEVICES) : r_data[7:0];
  assign w_id_match      = ((r_data ^ r_id) & r_mask) == 32'h0;
  assign w_idx_inc       = r_idx + 8'd1;
  assign w_last          = (w_idx_inc == r_count);
  assign w_unused_int    = i_wbm_int;

`ifdef DRT_FINDER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_tmo_enter;

  assign w_tmo_enter = (w_state_nxt != r_state) &&
                       ((w_state_nxt == S_WAIT_ACK) || (w_state_nxt == S_WAIT_ACK_LOW));
  assign w_timeout_hit = ((r_state == S_WAIT_ACK) || (r_state == S_WAIT_ACK_LOW)) &&
                         (r_tmo_cnt >= TMO_W'(TIMEOUT_CYCLES));

  // Ack-wait counter: restarts on each entry to an ack-wait state, saturates at the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_tmo_enter) begin
      r_tmo_cnt <= '0;
    end else if (r_tmo_cnt < TMO_W'(TIMEOUT_CYCLES)) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end
`else
  logic [31:0] w_unused_tmo;
  assign w_unused_tmo  = 32'(TIMEOUT_CYCLES);
  // Without the timeout the abort path is constant-false, so o_timeout folds to 0.
  assign w_timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode: bus handshake sequencing and the per-phase scan decision.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:         if (i_start) w_state_nxt = S_REQ;
      S_REQ:          w_state_nxt = S_WAIT_ACK;
      S_WAIT_ACK:     if (i_wbm_ack) w_state_nxt = S_WAIT_ACK_LOW;
                      else if (w_timeout_hit) w_state_nxt = S_DONE;
      S_WAIT_ACK_LOW: if (!i_wbm_ack) w_state_nxt = S_EVAL;
                      else if (w_timeout_hit) w_state_nxt = S_DONE;
      S_EVAL: begin
        case (r_phase)
          PH_COUNT: w_state_nxt = (w_count_clamped == 8'd0) ? S_DONE : S_REQ;
          PH_ID:    w_state_nxt = (w_id_match || !w_last) ? S_REQ : S_DONE;
          PH_OFF:   w_state_nxt = S_REQ;
          default:  w_state_nxt = S_DONE;
        endcase
      end
      S_DONE:         w_state_nxt = S_IDLE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: bus strobes, address walk, captured read data and scan results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase <= PH_COUNT;  r_data <= '0;      r_id <= '0;        r_mask <= '0;
      r_adr <= '0;          r_idx <= '0;       r_count <= '0;     r_cyc <= 1'b0;
      r_stb <= 1'b0;        r_busy <= 1'b0;    r_done <= 1'b0;    r_found <= 1'b0;
      r_timeout <= 1'b0;    r_dev_index <= '0; r_mem_offset <= '0; r_mem_size <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_id <= i_dev_id;    r_mask <= i_dev_mask;  r_busy <= 1'b1;
          r_found <= 1'b0;     r_timeout <= 1'b0;     r_dev_index <= '0;
          r_mem_offset <= '0;  r_mem_size <= '0;      r_idx <= '0;
          r_adr <= DRT_BASE_ADR + 32'd1;
          r_phase <= PH_COUNT;
        end
        S_REQ: begin
          r_cyc <= 1'b1;
          r_stb <= 1'b1;
        end
        S_WAIT_ACK, S_WAIT_ACK_LOW: begin
          if (r_state == S_WAIT_ACK && i_wbm_ack) begin
            r_data <= i_wbm_dat;
            r_stb  <= 1'b0;
          end else if (w_state_nxt == S_DONE) begin
            r_cyc <= 1'b0;  r_stb <= 1'b0;  r_timeout <= 1'b1;  r_found <= 1'b0;
          end
        end
        S_EVAL: begin
          case (r_phase)
            PH_COUNT: begin
              r_count <= w_count_clamped;
              if (w_count_clamped == 8'd0) r_cyc <= 1'b0;
              else begin
                r_idx   <= '0;
                r_adr   <= entry_adr(8'd0, 2'd0);
                r_phase <= PH_ID;
              end
            end
            PH_ID: begin
              if (w_id_match) begin
                r_dev_index <= r_idx;
                r_adr       <= entry_adr(r_idx, 2'd2);
                r_phase     <= PH_OFF;
              end else if (w_last) r_cyc <= 1'b0;
              else begin
                r_idx <= w_idx_inc;
                r_adr <= entry_adr(w_idx_inc, 2'd0);
              end
            end
            PH_OFF: begin
              r_mem_offset <= r_data;
              r_adr        <= entry_adr(r_idx, 2'd3);
              r_phase      <= PH_SIZE;
            end
            default: begin
              r_mem_size <= r_data;
              r_found    <= 1'b1;
              r_cyc      <= 1'b0;
            end
          endcase
        end
        S_DONE: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_found      = r_found;
  assign o_timeout    = r_timeout;
  assign o_dev_index  = r_dev_index;
  assign o_mem_offset = r_mem_offset;
  assign o_mem_size   = r_mem_size;
  assign o_wbm_cyc    = r_cyc;
  assign o_wbm_stb    = r_stb;
  assign o_wbm_we     = 1'b0;
  assign o_wbm_sel    = 4'hF;
  assign o_wbm_adr    = r_adr;
  assign o_wbm_dat    = 32'h0;

endmodule

// File: tb/tb_drt_device_finder.sv
// Bench for drt_device_finder: memory-backed Wishbone slave with adjustable ack latency and
// ack hold, a reference scan model over the same memory, and an o_done-time result check.
module tb_drt_device_finder;

  logic        clk = 1'b0, rst = 1'b1, i_start = 1'b0;
  logic [31:0] i_dev_id = '0, i_dev_mask = '0;
  logic        o_busy, o_done, o_found, o_timeout;
  logic [7:0]  o_dev_index;
  logic [31:0] o_mem_offset, o_mem_size, o_wbm_adr, o_wbm_dat;
  logic        o_wbm_cyc, o_wbm_stb, o_wbm_we;
  logic [3:0]  o_wbm_sel;
  logic [31:0] s_rdat = '0;
  logic        s_ack = 1'b0;

  always #5 clk = ~clk;

  drt_device_finder dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_dev_id(i_dev_id), .i_dev_mask(i_dev_mask),
    .o_busy(o_busy), .o_done(o_done), .o_found(o_found), .o_timeout(o_timeout),
    .o_dev_index(o_dev_index), .o_mem_offset(o_mem_offset), .o_mem_size(o_mem_size),
    .o_wbm_cyc(o_wbm_cyc), .o_wbm_stb(o_wbm_stb), .o_wbm_we(o_wbm_we), .o_wbm_sel(o_wbm_sel),
    .o_wbm_adr(o_wbm_adr), .o_wbm_dat(o_wbm_dat), .i_wbm_dat(s_rdat), .i_wbm_ack(s_ack),
    .i_wbm_int(1'b0)
  );

  int vectors = 0, miscompares = 0;
  logic [31:0] mem [256];

  // Expected results for the scan in flight.
  logic [31:0] exp_adr_q [$];
  logic        exp_found, exp_tmo;
  logic [7:0]  exp_idx;
  logic [31:0] exp_off, exp_size;
  int          done_cnt = 0, rd_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", nm, act, req);
    end
  endtask

  // Reference scan: follow the DRT rules over mem and record every address that must be read.
  task automatic model(input logic [31:0] id, input logic [31:0] mask);
    int unsigned n;
    logic [31:0] a;
    exp_adr_q.delete();
    exp_found = 1'b0; exp_tmo = 1'b0; exp_idx = '0; exp_off = '0; exp_size = '0;
    exp_adr_q.push_back(32'd1);
    n = (mem[1] > 32'd16) ? 16 : mem[1];
    for (int unsigned k = 0; k < n; k++) begin
      a = 32'd8 + k * 32'd8;
      exp_adr_q.push_back(a);
      if (((mem[a[7:0]] ^ id) & mask) == 32'h0) begin
        exp_adr_q.push_back(a + 32'd2);
        exp_adr_q.push_back(a + 32'd3);
        exp_found = 1'b1;
        exp_idx   = 8'(k);
        exp_off   = mem[8'(a + 32'd2)];
        exp_size  = mem[8'(a + 32'd3)];
        break;
      end
    end
  endtask

  // Slave: ack s_dly cycles late, keep ack s_hold extra cycles after stb falls, or never ack.
  int s_dly = 0, s_hold = 0, s_st = 0, s_cnt = 0;
  bit s_never = 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack <= 1'b0; s_st <= 0;
    end else if (!o_wbm_cyc) begin
      s_ack <= 1'b0; s_st <= 0;
    end else begin
      case (s_st)
        0, 1: begin
          if (o_wbm_stb && !s_never && (s_st == 1 ? s_cnt == 0 : s_dly == 0)) begin
            s_ack  <= 1'b1;
            s_rdat <= mem[o_wbm_adr[7:0]];
            rd_count++;
            if (exp_adr_q.size() == 0) chk("extra_read_adr", o_wbm_adr, 32'hFFFFFFFF);
            else chk("read_adr", o_wbm_adr, exp_adr_q.pop_front());
            s_st <= 2;
          end else if (s_st == 0 && o_wbm_stb && !s_never) begin
            s_cnt <= s_dly - 1; s_st <= 1;
          end else if (s_st == 1) s_cnt <= s_cnt - 1;
        end
        2: if (!o_wbm_stb) begin
          if (s_hold == 0) begin s_ack <= 1'b0; s_st <= 0; end
          else begin s_cnt <= s_hold - 1; s_st <= 3; end
        end
        default: begin
          chk("stb_during_stale_ack", {31'b0, o_wbm_stb}, 32'd0);
          if (s_cnt == 0) begin s_ack <= 1'b0; s_st <= 0; end
          else s_cnt <= s_cnt - 1;
        end
      endcase
    end
  end

  // Per-cycle compare on the falling edge: bus constants while strobing, full result at o_done.
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (rst) prev_busy = 1'b0;
    else begin
      if (o_wbm_stb) begin
        chk("cyc_with_stb", {31'b0, o_wbm_cyc}, 32'd1);
        chk("we_sel_dat", {o_wbm_we, o_wbm_sel, o_wbm_dat[26:0]}, {1'b0, 4'hF, 27'd0});
      end
      if (o_done) begin
        done_cnt++;
        chk("done_busy_was_high", {31'b0, prev_busy}, 32'd1);
        chk("done_busy_cyc_stb", {29'b0, o_busy, o_wbm_cyc, o_wbm_stb}, 32'd0);
        chk("done_found", {31'b0, o_found}, {31'b0, exp_found});
        chk("done_timeout", {31'b0, o_timeout}, {31'b0, exp_tmo});
        chk("done_index", {24'b0, o_dev_index}, {24'b0, exp_idx});
        chk("done_offset", o_mem_offset, exp_off);
        chk("done_size", o_mem_size, exp_size);
      end
      prev_busy = o_busy;
    end
  end

  task automatic pulse_start(input logic [31:0] id, input logic [31:0] mask);
    @(posedge clk); #1;
    i_start = 1'b1; i_dev_id = id; i_dev_mask = mask;
    @(posedge clk); #1;
    i_start = 1'b0; i_dev_id = $urandom; i_dev_mask = $urandom;
  endtask

  // One scan from start to o_done, with bounded wait; poke re-pulses start mid-scan.
  task automatic run_scan(input logic [31:0] id, input logic [31:0] mask, input bit poke,
                          input int bound);
    done_cnt = 0; rd_count = 0;
    pulse_start(id, mask);
    if (poke) begin
      repeat (6) @(posedge clk);
      pulse_start(~id, 32'h0);
    end
    for (int c = 0; c < bound && done_cnt == 0; c++) @(posedge clk);
    if (done_cnt == 0) begin
      vectors++; miscompares++;
      $display("FAIL scan_bound: got no o_done in %0d cycles, expected one", bound);
    end
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("done_pulses", done_cnt, 32'd1);
    chk("reads_left", exp_adr_q.size(), 32'd0);
    chk("hold_found", {31'b0, o_found}, {31'b0, exp_found});
    chk("hold_offset", o_mem_offset, exp_off);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[1] = 32'd2;
    mem[8] = 32'h00010001;
    mem[16] = 32'h00020001; mem[18] = 32'h01000000; mem[19] = 32'h00000100;
  endtask

  initial begin
    logic [31:0] lit [5];
    lit = '{32'd1, 32'd8, 32'd16, 32'd18, 32'd19};

    // Reset state.
    repeat (2) @(posedge clk); #1;
    chk("rst_outputs", {o_busy, o_done, o_found, o_timeout, o_wbm_cyc, o_wbm_stb, o_wbm_we},
        32'd0);
    chk("rst_sel", {28'b0, o_wbm_sel}, 32'hF);
    chk("rst_adr_off_size", o_wbm_adr | o_mem_offset | o_mem_size | {24'b0, o_dev_index}, 32'd0);
    rst = 1'b0;

    // Match at index 1; literal expectations pin the model first.
    load_basic();
    model(32'h00020000, 32'hFFFF0000);
    chk("model_reads", exp_adr_q.size(), 32'd5);
    for (int i = 0; i < 5; i++) chk("model_adr", exp_adr_q[i], lit[i]);
    chk("model_result", {exp_found, exp_idx, exp_size[22:0]}, {1'b1, 8'd1, 23'h100});
    run_scan(32'h00020000, 32'hFFFF0000, 1'b0, 500);
    chk("lit_index", {24'b0, o_dev_index}, 32'd1);
    chk("lit_offset", o_mem_offset, 32'h01000000);
    chk("lit_size", o_mem_size, 32'h00000100);

    // No match: reads 1, 8, 16 and zeroed results.
    model(32'h00030000, 32'hFFFF0000);
    chk("model_nomatch_reads", exp_adr_q.size(), 32'd3);
    run_scan(32'h00030000, 32'hFFFF0000, 1'b0, 500);
    chk("lit_nomatch_found", {31'b0, o_found}, 32'd0);

    // Empty table.
    mem[1] = 32'd0;
    model(32'h0, 32'h0);
    run_scan(32'h0, 32'h0, 1'b0, 500);
    chk("count0_reads", rd_count, 32'd1);

    // Oversized count clamps at 16 entries.
    for (int i = 8; i < 256; i++) mem[i] = 32'h0;
    mem[1] = 32'd40;
    model(32'hFFFFFFFF, 32'hFFFFFFFF);
    run_scan(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1000);
    chk("clamp_reads", rd_count, 32'd17);

    // Late ack held 3 cycles after stb falls, plus a start pulse while busy.
    load_basic();
    s_dly = 3; s_hold = 3;
    model(32'h00020000, 32'hFFFF0000);
    run_scan(32'h00020000, 32'hFFFF0000, 1'b1, 1000);
    chk("slow_size", o_mem_size, 32'h00000100);

    // Randomized tables, IDs, masks and slave timing.
    for (int it = 0; it < 30; it++) begin
      logic [31:0] id, mask;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[1] = $urandom_range(0, 20);
      for (int k = 0; k < 20; k++) mem[8 + k * 8] = ($urandom_range(0, 7) << 16) | ($urandom & 32'hFFFF);
      id   = $urandom_range(0, 7) << 16;
      mask = ($urandom_range(0, 3) == 0) ? $urandom : 32'hFFFF0000;
      s_dly = $urandom_range(0, 3); s_hold = $urandom_range(0, 3);
      model(id, mask);
      run_scan(id, mask, $urandom_range(0, 3) == 0, 1500);
    end
    s_dly = 0; s_hold = 0;

`ifdef DRT_FINDER_TIMEOUT_EN
    // Silent slave: scan aborts with o_timeout.
    load_basic();
    s_never = 1'b1;
    model(32'h00020000, 32'hFFFF0000);
    exp_adr_q.delete(); exp_tmo = 1'b1; exp_found = 1'b0; exp_idx = '0; exp_off = '0; exp_size = '0;
    run_scan(32'h00020000, 32'hFFFF0000, 1'b0, 400);
    chk("tmo_flag", {31'b0, o_timeout}, 32'd1);
    s_never = 1'b0;
`endif

    // Reset in the middle of an ack wait, then a clean scan.
    load_basic();
    s_never = 1'b1;
    exp_adr_q.delete();
    pulse_start(32'h00020000, 32'hFFFF0000);
    for (int c = 0; c < 20 && !o_wbm_stb; c++) @(posedge clk);
    chk("midrst_stb_seen", {31'b0, o_wbm_stb}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("midrst_cyc_stb_busy", {29'b0, o_wbm_cyc, o_wbm_stb, o_busy}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    s_never = 1'b0;
    model(32'h00020000, 32'hFFFF0000);
    run_scan(32'h00020000, 32'hFFFF0000, 1'b0, 500);
    chk("post_rst_index", {24'b0, o_dev_index}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
